// File: rtl/muldiv_pkg.sv
// muldiv_pkg: shared constants and types for the RV64M multiply/divide sequencer.
//   - opcode / funct7 / funct3 encodings of the M extension
//   - sequencer state enum and operation-class enum
//   - sext32 helper used for W-form results
package muldiv_pkg;

    localparam logic [6:0] OP_REG        = 7'b0110011;
    localparam logic [6:0] OP_REG32      = 7'b0111011;
    localparam logic [6:0] FUNCT7_MULDIV = 7'b0000001;

    localparam logic [2:0] F3_MUL    = 3'd0;
    localparam logic [2:0] F3_MULH   = 3'd1;
    localparam logic [2:0] F3_MULHSU = 3'd2;
    localparam logic [2:0] F3_MULHU  = 3'd3;
    localparam logic [2:0] F3_DIV    = 3'd4;
    localparam logic [2:0] F3_DIVU   = 3'd5;
    localparam logic [2:0] F3_REM    = 3'd6;
    localparam logic [2:0] F3_REMU   = 3'd7;

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_e;
    typedef enum logic [1:0] {MUL_LO, MUL_HI, DIV_Q, DIV_R} op_cls_e;

    function automatic logic [63:0] sext32(input logic [31:0] v);
        return {{32{v[31]}}, v};
    endfunction

endpackage

// File: rtl/muldiv_decode.sv
// muldiv_decode: combinational M-extension decoder for the exe-stage instruction.
// Ports:
//   exe_V, exe_IR       : exe instruction valid / instruction word
//   md_req              : valid MUL/DIV instruction present in exe
//   is_word             : W form (OP-32 opcode), operates on bits [31:0]
//   op_cls              : low product, high product, quotient or remainder
//   rs1_signed/rs2_signed : operand treated as two's complement
module muldiv_decode
    import muldiv_pkg::*;
(
    input  logic        exe_V,
    input  logic [31:0] exe_IR,
    output logic        md_req,
    output logic        is_word,
    output op_cls_e     op_cls,
    output logic        rs1_signed,
    output logic        rs2_signed
);

    logic [6:0] opcode;
    logic [6:0] funct7;
    logic [2:0] funct3;
    logic       unused_ir;

    assign opcode    = exe_IR[6:0];
    assign funct3    = exe_IR[14:12];
    assign funct7    = exe_IR[31:25];
    assign unused_ir = ^{exe_IR[24:15], exe_IR[11:7]};

    always_comb begin
        is_word    = (opcode == OP_REG32);
        // MULH/MULHSU/MULHU have no W form
        md_req     = exe_V && (funct7 == FUNCT7_MULDIV) &&
                     ((opcode == OP_REG) ||
                      (is_word && !(funct3 inside {F3_MULH, F3_MULHSU, F3_MULHU})));
        op_cls     = MUL_LO;
        rs1_signed = 1'b0;
        rs2_signed = 1'b0;
        // MUL/MULW keep the low half only, which is sign-agnostic: run unsigned
        case (funct3)
            F3_MUL:    op_cls = MUL_LO;
            F3_MULH:   begin op_cls = MUL_HI; rs1_signed = 1'b1; rs2_signed = 1'b1; end
            F3_MULHSU: begin op_cls = MUL_HI; rs1_signed = 1'b1; end
            F3_MULHU:  op_cls = MUL_HI;
            F3_DIV:    begin op_cls = DIV_Q;  rs1_signed = 1'b1; rs2_signed = 1'b1; end
            F3_DIVU:   op_cls = DIV_Q;
            F3_REM:    begin op_cls = DIV_R;  rs1_signed = 1'b1; rs2_signed = 1'b1; end
            default:   op_cls = DIV_R;
        endcase
    end

endmodule

// File: rtl/muldiv_seq.sv
// muldiv_seq: iterative RV64M multiply/divide sequencer beside the exe ALU.
// Multiplies run a radix-2^UNROLL shift-add on operand magnitudes; divides run a
// restoring divide on magnitudes. Signs are fixed up on the final CALC cycle.
// Ports:
//   clk, rst_n            : clock (rising edge), async active-low reset
//   exe_V/exe_IR          : exe instruction valid / word
//   exe_ALU1/exe_ALU2     : rs1 / rs2 operands
//   mem_stall             : downstream stall, holds the result in DONE
//   flush                 : kill in-flight operation
//   md_stall              : hold fetch/decode/exe while the result is pending
//   md_valid/md_result    : result for the exe->mem capture
//   md_busy               : sequencer not idle
// Optional: define MULDIV_EARLY_OUT_EN to finish a multiply as soon as the
// remaining multiplier bits are all zero.
// UNROLL must be 1, 2 or 4.
module muldiv_seq
    import muldiv_pkg::*;
#(
    parameter int XLEN   = 64,
    parameter int UNROLL = 1
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            exe_V,
    input  logic [31:0]     exe_IR,
    input  logic [XLEN-1:0] exe_ALU1,
    input  logic [XLEN-1:0] exe_ALU2,
    input  logic            mem_stall,
    input  logic            flush,
    output logic            md_stall,
    output logic            md_valid,
    output logic            md_busy,
    output logic [XLEN-1:0] md_result
);

    localparam logic [6:0] N64 = 7'(64 / UNROLL);
    localparam logic [6:0] N32 = 7'(32 / UNROLL);

    // decode
    logic    md_req, is_word, rs1_signed, rs2_signed;
    op_cls_e op_cls;

    muldiv_decode u_decode (
        .exe_V      (exe_V),
        .exe_IR     (exe_IR),
        .md_req     (md_req),
        .is_word    (is_word),
        .op_cls     (op_cls),
        .rs1_signed (rs1_signed),
        .rs2_signed (rs2_signed)
    );

    // state
    state_e        state_q, state_d;
    logic [6:0]    cnt_q, cnt_d;
    logic [127:0]  acc_q, acc_d;     // mul: {partial product, multiplier}; div: {remainder, quotient}
    logic [63:0]   mcand_q, mcand_d; // mul: multiplicand magnitude; div: divisor magnitude
    op_cls_e       op_q, op_d;
    logic          word_q, word_d;
    logic          neg_q, neg_d;     // negate the selected result on completion
    logic [63:0]   result_q, result_d;

    // operand preparation
    logic [63:0] a_ext, b_ext, mag1, mag2, spec_res;
    logic        s1neg, s2neg, req_div, div_zero, div_ovf, special, start, finish;

    assign a_ext    = is_word ? (rs1_signed ? sext32(exe_ALU1[31:0]) : {32'b0, exe_ALU1[31:0]}) : exe_ALU1;
    assign b_ext    = is_word ? (rs2_signed ? sext32(exe_ALU2[31:0]) : {32'b0, exe_ALU2[31:0]}) : exe_ALU2;
    assign s1neg    = rs1_signed && a_ext[63];
    assign s2neg    = rs2_signed && b_ext[63];
    assign mag1     = s1neg ? -a_ext : a_ext;
    assign mag2     = s2neg ? -b_ext : b_ext;
    assign req_div  = (op_cls == DIV_Q) || (op_cls == DIV_R);
    assign div_zero = (b_ext == 64'd0);
    // a_ext is already sign-extended for signed W forms, so one compare covers both widths
    assign div_ovf  = rs1_signed && (&b_ext) &&
                      (a_ext == (is_word ? 64'hFFFF_FFFF_8000_0000 : 64'h8000_0000_0000_0000));
    assign special  = req_div && (div_zero || div_ovf);
    assign start    = (state_q == IDLE) && md_req && !flush;

    always_comb begin
        spec_res = 64'd0;
        if (div_zero)
            spec_res = (op_cls == DIV_Q) ? {64{1'b1}}
                                         : (is_word ? sext32(exe_ALU1[31:0]) : exe_ALU1);
        else if (op_cls == DIV_Q)
            spec_res = a_ext;
    end

    // iteration datapath
    logic [127:0] acc_step, acc_fin, prod;
    logic [63:0]  q_fix, r_fix, fin_res;
    logic         is_mul, early;

    assign is_mul = (op_q == MUL_LO) || (op_q == MUL_HI);

    always_comb begin
        logic [64:0] sum;
        logic [64:0] rem;
        logic [63:0] quo;
        sum      = 65'd0;
        rem      = 65'd0;
        quo      = 64'd0;
        acc_step = acc_q;
        for (int i = 0; i < UNROLL; i++) begin
            if (is_mul) begin
                sum      = {1'b0, acc_step[127:64]} + (acc_step[0] ? {1'b0, mcand_q} : 65'd0);
                acc_step = {sum, acc_step[63:1]};
            end else begin
                rem = {acc_step[127:64], acc_step[63]};
                quo = {acc_step[62:0], 1'b0};
                if (rem >= {1'b0, mcand_q}) begin
                    rem    = rem - {1'b0, mcand_q};
                    quo[0] = 1'b1;
                end
                acc_step = {rem[63:0], quo};
            end
        end

        acc_fin = acc_step;
        early   = 1'b0;
`ifdef MULDIV_EARLY_OUT_EN
        begin
            logic [6:0]  rem_steps;
            logic [63:0] mask;
            // the low rem_steps bits of the accumulator hold the unconsumed multiplier;
            // when zero, the remaining steps are pure right shifts
            rem_steps = 7'(cnt_q * UNROLL);
            mask      = ~({64{1'b1}} << rem_steps);
            if (is_mul && ((acc_q[63:0] & mask) == 64'd0)) begin
                early   = 1'b1;
                acc_fin = acc_q >> rem_steps;
            end
        end
`endif

        // W forms leave the 32-bit results at [63:32] (mul) or [31:0] (div)
        prod  = neg_q ? -acc_fin : acc_fin;
        q_fix = neg_q ? -acc_fin[63:0]   : acc_fin[63:0];
        r_fix = neg_q ? -acc_fin[127:64] : acc_fin[127:64];
        case (op_q)
            MUL_LO:  fin_res = word_q ? sext32(prod[63:32]) : prod[63:0];
            MUL_HI:  fin_res = prod[127:64];
            DIV_Q:   fin_res = word_q ? sext32(q_fix[31:0]) : q_fix;
            default: fin_res = word_q ? sext32(r_fix[31:0]) : r_fix;
        endcase
    end

    assign finish = (state_q == CALC) && md_req && !flush && ((cnt_q == 7'd1) || early);

    // state register
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q  <= IDLE;
            cnt_q    <= 7'd0;
            acc_q    <= 128'd0;
            mcand_q  <= 64'd0;
            op_q     <= MUL_LO;
            word_q   <= 1'b0;
            neg_q    <= 1'b0;
            result_q <= 64'd0;
        end else begin
            state_q  <= state_d;
            cnt_q    <= cnt_d;
            acc_q    <= acc_d;
            mcand_q  <= mcand_d;
            op_q     <= op_d;
            word_q   <= word_d;
            neg_q    <= neg_d;
            result_q <= result_d;
        end
    end

    // next state
    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE: if (start) state_d = special ? DONE : CALC;
            CALC: begin
                if (flush || !md_req) state_d = IDLE;
                else if (finish)      state_d = DONE;
            end
            DONE:    if (flush || !mem_stall) state_d = IDLE;
            default: state_d = IDLE;
        endcase
    end

    // datapath next values
    always_comb begin
        cnt_d    = cnt_q;
        acc_d    = acc_q;
        mcand_d  = mcand_q;
        op_d     = op_q;
        word_d   = word_q;
        neg_d    = neg_q;
        result_d = result_q;
        if (start) begin
            op_d   = op_cls;
            word_d = is_word;
            if (special) begin
                cnt_d    = 7'd0;
                result_d = spec_res;
            end else begin
                cnt_d = is_word ? N32 : N64;
                if (req_div) begin
                    // dividend top-aligned so the first shift brings in its MSB
                    acc_d   = {64'd0, is_word ? {mag1[31:0], 32'd0} : mag1};
                    mcand_d = mag2;
                    neg_d   = (op_cls == DIV_Q) ? (s1neg ^ s2neg) : s1neg;
                end else begin
                    acc_d   = {64'd0, mag2};
                    mcand_d = mag1;
                    neg_d   = s1neg ^ s2neg;
                end
            end
        end else if (state_q == CALC) begin
            if (flush || !md_req) begin
                cnt_d = 7'd0;
            end else if (finish) begin
                cnt_d    = 7'd0;
                acc_d    = acc_fin;
                result_d = fin_res;
            end else begin
                cnt_d = cnt_q - 7'd1;
                acc_d = acc_step;
            end
        end
    end

    // outputs
    always_comb begin
        md_busy   = (state_q != IDLE);
        md_valid  = (state_q == DONE) && !flush;
        // gated by rst_n so every output reads zero while reset is held
        md_stall  = md_req && (state_q != DONE) && rst_n;
        md_result = result_q;
    end

endmodule
